data_mem_ctrl: RTL

// - Single-ported data memory with a fixed-latency controller. Sits directly downstream of the finished store buffer.
// - Drains the buffer's one pending store via a grant pulse; the grant is the buffer's "memory write done" input.
// - Also serves load reads through a req/ready/valid port.
// - Arbitrates loads against the pending store on one array port, with a store-starvation bound.

---
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/data_mem_ctrl.sv | 77 +++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: groups the store-drain and load port signals of data_mem_ctrl.
//   master : store buffer / load requester side (drives wr_pending, wr_addr, wr_data, rd_req, rd_addr)
//   slave  : memory controller side (drives wr_grant, rd_ready, rd_valid, rd_data)
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 33
);
    logic              wr_pending;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_grant;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    modport master (
        output wr_pending, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_grant, rd_ready, rd_valid, rd_data
    );
    modport slave (
        input  wr_pending, wr_addr, wr_data, rd_req, rd_addr,
        output wr_grant, rd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-ported data memory with fixed-latency load/store controller and store-starvation bound.
//   clk  : clock, posedge
//   rst  : synchronous reset, active-low
//   bus  : data_mem_ctrl_if.slave (store drain: wr_pending/wr_addr/wr_data/wr_grant;
//          loads: rd_req/rd_addr/rd_ready/rd_valid/rd_data)
//   Optional macro DMEM_BYPASS_EN: forward the pending store's data to a same-address load.
module data_mem_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 33,
    parameter int LAT          = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;
    state_t            state, state_nx;
    logic [2:0]        lat_cnt, lat_nx;
    logic [3:0]        starve_cnt, starve_nx;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_data, rd_hold;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              last, rd_acc, wr_acc;
`ifdef DMEM_BYPASS_EN
    logic              fwd;
`endif
    // Outputs are gated by rst so a reset cycle never shows a grant, a load result or readiness.
    always_comb begin
        last         = lat_cnt == 3'(LAT);
        bus.rd_ready = rst && state == IDLE && !(bus.wr_pending && starve_cnt == 4'(STARVE_LIMIT));
        rd_acc       = bus.rd_req && bus.rd_ready;
        wr_acc       = rst && state == IDLE && bus.wr_pending && !rd_acc;
        bus.rd_valid = rst && state == RD_BUSY && last;
        bus.wr_grant = rst && state == WR_BUSY && last;
`ifdef DMEM_BYPASS_EN
        bus.rd_data  = bus.rd_valid ? (fwd ? op_data : mem[op_addr]) : rd_hold;
`else
        bus.rd_data  = bus.rd_valid ? mem[op_addr] : rd_hold;
`endif
        state_nx     = state == IDLE ? (rd_acc ? RD_BUSY : wr_acc ? WR_BUSY : IDLE) : (last ? IDLE : state);
        lat_nx       = state == IDLE ? 3'd1 : lat_cnt + 3'd1;
        starve_nx    = (!bus.wr_pending || bus.wr_grant) ? 4'd0 :
                       (rd_acc && starve_cnt != 4'(STARVE_LIMIT)) ? starve_cnt + 4'd1 : starve_cnt;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            lat_cnt    <= 3'd0;
            starve_cnt <= 4'd0;
            op_addr    <= '0;
            op_data    <= '0;
            rd_hold    <= '0;
`ifdef DMEM_BYPASS_EN
            fwd        <= 1'b0;
`endif
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else begin
            state      <= state_nx;
            lat_cnt    <= lat_nx;
            starve_cnt <= starve_nx;
            if (rd_acc) begin
                op_addr <= bus.rd_addr;
`ifdef DMEM_BYPASS_EN
                // op_data is free during a load, so it carries the forwarded store value.
                fwd     <= bus.wr_pending && bus.rd_addr == bus.wr_addr;
                op_data <= bus.wr_data;
`endif
            end else if (wr_acc) begin
                op_addr <= bus.wr_addr;
                op_data <= bus.wr_data;
            end
            if (bus.rd_valid) rd_hold <= bus.rd_data;
            if (bus.wr_grant) mem[op_addr] <= op_data;
        end
    end
endmodule
